// File: rtl/score_pkg.sv
// Shared types and constants for the dino-game score controller.
package score_pkg;

  typedef enum logic [1:0] {IDLE, RUN, OVER} game_state_e;
  typedef enum logic [1:0] {CV_IDLE, CV_SHIFT, CV_DONE} cv_state_e;

  localparam int unsigned MAX_SCORE  = 9999;
  localparam logic [2:0]  LEVEL_MAX  = 3'd7;
  localparam int unsigned BCD_DIGITS = 4;

  // Add-3 correction applied to every BCD digit before each shift.
  function automatic logic [4*BCD_DIGITS-1:0] bcd_adj(input logic [4*BCD_DIGITS-1:0] d);
    logic [4*BCD_DIGITS-1:0] r;
    r = d;
    for (int unsigned i = 0; i < BCD_DIGITS; i++) begin
      if (d[4*i +: 4] >= 4'd5) r[4*i +: 4] = d[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential shift-and-add-3 binary-to-BCD converter, one bit per cycle.
module bin2bcd_seq
  import score_pkg::*;
#(
  parameter int unsigned SCORE_W = 14
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      go,
  input  logic [SCORE_W-1:0]        bin,
  output logic                      busy,
  output logic                      done,
  output logic [4*BCD_DIGITS-1:0]   bcd
);

  localparam int unsigned CW = $clog2(SCORE_W + 1);

  cv_state_e               state_q, state_d;
  logic [SCORE_W-1:0]      bin_q, bin_d;
  logic [4*BCD_DIGITS-1:0] bcd_q, bcd_d, adj;
  logic [CW-1:0]           cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= CV_IDLE;
      bin_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    adj     = bcd_adj(bcd_q);
    case (state_q)
      CV_IDLE: begin
        if (go) begin
          bin_d   = bin;
          bcd_d   = '0;
          cnt_d   = '0;
          state_d = CV_SHIFT;
        end
      end
      CV_SHIFT: begin
        bcd_d = {adj[4*BCD_DIGITS-2:0], bin_q[SCORE_W-1]};
        bin_d = {bin_q[SCORE_W-2:0], 1'b0};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(SCORE_W - 1)) state_d = CV_DONE;
      end
      CV_DONE: state_d = CV_IDLE;
      default: state_d = CV_IDLE;
    endcase
  end

  assign busy = (state_q != CV_IDLE);
  assign done = (state_q == CV_DONE);
  assign bcd  = bcd_q;

endmodule

// File: rtl/score_ctrl.sv
// Dino-game score controller: game FSM, 1 Hz tick, level, shared BCD conversion.
// High-score tracking is built only when SCORE_HISCORE_EN is defined.
module score_ctrl
  import score_pkg::*;
#(
  parameter int unsigned TICK_DIV   = 50000000,
  parameter int unsigned SCORE_W    = 14,
  parameter int unsigned LEVEL_STEP = 100
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        start,
  input  logic        collide,
  output logic        running,
  output logic        game_over,
  output logic [2:0]  level,
  output logic [15:0] score_bcd,
  output logic [15:0] hi_bcd,
  output logic        bcd_valid
);

  localparam int unsigned PW = $clog2(TICK_DIV);
  localparam int unsigned SW = $clog2(LEVEL_STEP + 1);

  game_state_e        state_q, state_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [PW-1:0]      presc_q, presc_d;
  logic [SW-1:0]      step_q, step_d;
  logic [2:0]         level_q, level_d;
  logic               score_pend_q, score_pend_d;
  logic [15:0]        score_bcd_q, score_bcd_d;
  logic               bcd_valid_q, bcd_valid_d;
  logic               running_q, running_d;
  logic               game_over_q, game_over_d;
  logic               tick, score_req, grant_score;

  logic               cv_go, cv_busy, cv_done;
  logic [SCORE_W-1:0] cv_bin;
  logic [15:0]        cv_bcd;

`ifdef SCORE_HISCORE_EN
  logic [SCORE_W-1:0] hi_q, hi_d;
  logic               hi_pend_q, hi_pend_d;
  logic               tgt_hi_q, tgt_hi_d;
  logic [15:0]        hi_bcd_q, hi_bcd_d;
  logic               hi_req, grant_hi;

  // Fixed priority: the live score always wins over the high score.
  assign grant_hi    = !score_pend_q;
  assign cv_go       = !cv_busy && (score_pend_q || hi_pend_q);
  assign grant_score = cv_go && !grant_hi;
  assign cv_bin      = score_pend_q ? score_q : hi_q;
  assign hi_bcd      = hi_bcd_q;
`else
  assign cv_go       = !cv_busy && score_pend_q;
  assign grant_score = cv_go;
  assign cv_bin      = score_q;
  assign hi_bcd      = '0;
`endif

  bin2bcd_seq #(.SCORE_W(SCORE_W)) u_bin2bcd (
    .clk  (clk),
    .rstn (rstn),
    .go   (cv_go),
    .bin  (cv_bin),
    .busy (cv_busy),
    .done (cv_done),
    .bcd  (cv_bcd)
  );

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q      <= IDLE;
      score_q      <= '0;
      presc_q      <= '0;
      step_q       <= '0;
      level_q      <= '0;
      score_pend_q <= 1'b0;
      score_bcd_q  <= '0;
      bcd_valid_q  <= 1'b0;
      running_q    <= 1'b0;
      game_over_q  <= 1'b0;
`ifdef SCORE_HISCORE_EN
      hi_q         <= '0;
      hi_pend_q    <= 1'b0;
      tgt_hi_q     <= 1'b0;
      hi_bcd_q     <= '0;
`endif
    end else begin
      state_q      <= state_d;
      score_q      <= score_d;
      presc_q      <= presc_d;
      step_q       <= step_d;
      level_q      <= level_d;
      score_pend_q <= score_pend_d;
      score_bcd_q  <= score_bcd_d;
      bcd_valid_q  <= bcd_valid_d;
      running_q    <= running_d;
      game_over_q  <= game_over_d;
`ifdef SCORE_HISCORE_EN
      hi_q         <= hi_d;
      hi_pend_q    <= hi_pend_d;
      tgt_hi_q     <= tgt_hi_d;
      hi_bcd_q     <= hi_bcd_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    score_d   = score_q;
    presc_d   = presc_q;
    step_d    = step_q;
    level_d   = level_q;
    score_req = 1'b0;
`ifdef SCORE_HISCORE_EN
    hi_d      = hi_q;
    hi_req    = 1'b0;
`endif
    tick = (state_q == RUN) && (presc_q == PW'(TICK_DIV - 1));
    case (state_q)
      IDLE, OVER: begin
        if (start) begin
          state_d   = RUN;
          score_d   = '0;
          presc_d   = '0;
          step_d    = '0;
          level_d   = '0;
          score_req = 1'b1;
        end
      end
      RUN: begin
        // Collide takes precedence over a coincident tick.
        if (collide) begin
          state_d = OVER;
          presc_d = '0;
`ifdef SCORE_HISCORE_EN
          if (score_q > hi_q) begin
            hi_d   = score_q;
            hi_req = 1'b1;
          end
`endif
        end else begin
          presc_d = tick ? '0 : presc_q + PW'(1);
          if (tick) begin
            if (score_q < SCORE_W'(MAX_SCORE)) begin
              score_d   = score_q + SCORE_W'(1);
              score_req = 1'b1;
            end
            if (step_q == SW'(LEVEL_STEP - 1)) begin
              step_d = '0;
              if (level_q != LEVEL_MAX) level_d = level_q + 3'd1;
            end else begin
              step_d = step_q + SW'(1);
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A request on the grant edge re-arms the flag so the newest value follows.
  always_comb begin
    score_pend_d = score_req || (score_pend_q && !grant_score);
    score_bcd_d  = score_bcd_q;
    bcd_valid_d  = cv_done;
    running_d    = (state_d == RUN);
    game_over_d  = (state_d == OVER);
`ifdef SCORE_HISCORE_EN
    hi_pend_d    = hi_req || (hi_pend_q && !(cv_go && grant_hi));
    tgt_hi_d     = cv_go ? grant_hi : tgt_hi_q;
    hi_bcd_d     = hi_bcd_q;
    if (cv_done) begin
      if (tgt_hi_q) hi_bcd_d    = cv_bcd;
      else          score_bcd_d = cv_bcd;
    end
`else
    if (cv_done) score_bcd_d = cv_bcd;
`endif
  end

  assign running   = running_q;
  assign game_over = game_over_q;
  assign level     = level_q;
  assign score_bcd = score_bcd_q;
  assign bcd_valid = bcd_valid_q;

endmodule
